// File: rtl/cia_pipe_adder.sv
// cia_pipe_adder: two-stage pipelined carry-increment adder/subtractor.
// Stage 1 registers bit propagate terms and per-group ripple prefixes.
// Stage 2 resolves the group carry chain and holds sum/cout/ovf/zero.
// Valid/ready handshakes on both sides. At most two beats are in flight.
`timescale 1ns/1ps

module cia_pipe_adder #(
   parameter int N        = 64,
   parameter int GS       = 8,
   parameter int FLAGS_EN = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         ovf,
   output logic         zero
);

   // Number of carry-increment groups; the last one may be narrower than GS.
   localparam int   NG  = (N + GS - 1) / GS;
   localparam logic FLG = (FLAGS_EN != 0);

   // Marks the most significant bit of every group (including a partial last group).
   function automatic logic [N-1:0] grp_msb_mask();
      logic [N-1:0] m;
      m = '0;
      for (int i = 0; i < N; i++) begin
         m[i] = ((i % GS) == (GS - 1)) || (i == N - 1);
      end
      return m;
   endfunction

   localparam logic [N-1:0] GRP_MSB = grp_msb_mask();

   // ---------------------------------------------------------------
   // Flow control
   // ---------------------------------------------------------------
   logic s1_valid, s2_valid;
   logic s1_load, s2_load;

   // Stage 1 can take a beat whenever some stage is empty or the output drains.
   assign in_ready  = ~s1_valid | ~s2_valid | out_ready;
   assign s1_load   = in_valid & in_ready;
   assign s2_load   = s1_valid & (~s2_valid | out_ready);
   assign out_valid = s2_valid;

   // Stage occupancy: a stage fills on load and empties when its beat moves on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples the pre-edge values regardless of statement order.
         if (s1_load)
            s1_valid <= 1'b1;
         else if (s2_load)
            s1_valid <= 1'b0;

         if (s2_load)
            s2_valid <= 1'b1;
         else if (out_ready)
            s2_valid <= 1'b0;
      end
   end

   // ---------------------------------------------------------------
   // Stage 1: operand conditioning and per-group local prefixes
   // ---------------------------------------------------------------
   logic [N-1:0]  bb, g, p;
   logic          c0_n;
   logic [N-1:0]  gl_n, pl_n;
   logic [NG-1:0] gg_n, gp_n;

   // Subtraction is a + ~b + 1, so cin is replaced by a forced carry of 1.
   always_comb begin
      bb   = sub ? ~b : b;
      c0_n = sub ? 1'b1 : cin;
      g    = a & bb;
      p    = a ^ bb;
   end

   // Ripple prefix inside each group, relative to the group LSB (carry-in 0).
   always_comb begin
      logic gacc;
      logic pacc;
      // NOTE: every output of a combinational block gets a default first so
      // no path leaves it unassigned and no latch is inferred.
      gl_n = '0;
      pl_n = '0;
      gg_n = '0;
      gp_n = '0;
      gacc = 1'b0;
      pacc = 1'b0;
      for (int i = 0; i < N; i++) begin
         if ((i % GS) == 0) begin
            gacc = g[i];
            pacc = p[i];
         end else begin
            gacc = g[i] | (p[i] & gacc);
            pacc = p[i] & pacc;
         end
         gl_n[i] = gacc;
         pl_n[i] = pacc;
         if (GRP_MSB[i]) begin
            gg_n[i / GS] = gacc;
            gp_n[i / GS] = pacc;
         end
      end
   end

   logic [N-1:0]  s1_p, s1_gl, s1_pl;
   logic [NG-1:0] s1_gg, s1_gp;
   logic          s1_c0, s1_amsb, s1_bmsb;

   // Stage 1 register: captures the prefix terms on an input transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_p    <= '0;
         s1_gl   <= '0;
         s1_pl   <= '0;
         s1_gg   <= '0;
         s1_gp   <= '0;
         s1_c0   <= 1'b0;
         s1_amsb <= 1'b0;
         s1_bmsb <= 1'b0;
      end else if (s1_load) begin
         s1_p    <= p;
         s1_gl   <= gl_n;
         s1_pl   <= pl_n;
         s1_gg   <= gg_n;
         s1_gp   <= gp_n;
         s1_c0   <= c0_n;
         s1_amsb <= a[N-1];
         s1_bmsb <= bb[N-1];
      end
   end

   // Local terms at each group MSB travel as GG/GP instead; fold them into a sink.
   logic grp_msb_unused;
   assign grp_msb_unused = ^((s1_gl | s1_pl) & GRP_MSB);

   // ---------------------------------------------------------------
   // Stage 2: group carry chain, sum and flags
   // ---------------------------------------------------------------
   logic [N-1:0] sum_n;
   logic         cout_n, ovf_n, zero_n;

   // Carry into each group ripples across groups; bits inside a group use
   // their registered local prefix combined with that group carry.
   always_comb begin
      logic cg;
      logic ci;
      sum_n = '0;
      cg    = s1_c0;
      ci    = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (((i % GS) == 0) && (i != 0))
            cg = s1_gg[i / GS - 1] | (s1_gp[i / GS - 1] & cg);
         if ((i % GS) == 0)
            ci = cg;
         else
            ci = s1_gl[i - 1] | (s1_pl[i - 1] & cg);
         sum_n[i] = s1_p[i] ^ ci;
      end
      cout_n = s1_gg[NG-1] | (s1_gp[NG-1] & cg);
   end

   // Flags: overflow when like-signed operands give a differently-signed result.
   always_comb begin
      ovf_n  = FLG & ~(s1_amsb ^ s1_bmsb) & (sum_n[N-1] ^ s1_amsb);
      zero_n = FLG & ~|sum_n;
   end

   // Output register: loads when the beat in stage 1 may advance, else holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum  <= '0;
         cout <= 1'b0;
         ovf  <= 1'b0;
         zero <= 1'b0;
      end else if (s2_load) begin
         sum  <= sum_n;
         cout <= cout_n;
         ovf  <= ovf_n;
         zero <= zero_n;
      end
   end

endmodule

// File: tb/tb_cia_pipe_adder.sv
// tb_cia_pipe_adder: drives eight cia_pipe_adder configurations with one
// shared stimulus stream and checks every one against an arithmetic model
// (queue of in-flight beats, plain a+b+cin / a-b results) on every cycle.
`timescale 1ns/1ps

module tb_cia_pipe_adder;

   localparam int NCFG = 8;

   function automatic int cfg_n(int k);
      return (k < 5) ? 64 : 8;
   endfunction

   function automatic int cfg_gs(int k);
      case (k)
         0: return 8;
         1: return 7;
         2: return 1;
         3: return 3;
         4: return 64;
         5: return 3;
         6: return 1;
         default: return 8;
      endcase
   endfunction

   function automatic int cfg_fl(int k);
      return (k == 7) ? 0 : 1;
   endfunction

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        cin;
      logic        sub;
      int          t;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, cin, sub, out_ready;
   logic [63:0] a, b;

   logic [63:0] sum_x  [NCFG];
   logic        cout_x [NCFG];
   logic        ovf_x  [NCFG];
   logic        zero_x [NCFG];
   logic        rdy_x  [NCFG];
   logic        vld_x  [NCFG];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NCFG; g++) begin : gen_dut
      localparam int NW = cfg_n(g);
      localparam int GW = cfg_gs(g);
      localparam int FW = cfg_fl(g);
      logic [NW-1:0] s;
      cia_pipe_adder #(.N(NW), .GS(GW), .FLAGS_EN(FW)) dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_valid (in_valid),
         .in_ready (rdy_x[g]),
         .a        (a[NW-1:0]),
         .b        (b[NW-1:0]),
         .cin      (cin),
         .sub      (sub),
         .out_valid(vld_x[g]),
         .out_ready(out_ready),
         .sum      (s),
         .cout     (cout_x[g]),
         .ovf      (ovf_x[g]),
         .zero     (zero_x[g])
      );
      assign sum_x[g] = 64'(s);
   end

   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc   = 0;
   int          pops  = 0;
   beat_t       q[$];
   logic [63:0] obs[$];
   int          obs_cyc[$];
   logic [63:0] last_sum  [NCFG];
   logic        last_cout [NCFG];
   logic        last_ovf  [NCFG];
   logic        last_zero [NCFG];

   task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL cfg%0d %s: got %h expected %h (cycle %0d)", k, name, act, exp, cyc);
      end
   endtask

   // Golden result from plain arithmetic on an n-bit slice of the operands.
   function automatic void ref_calc(input beat_t bt, input int n, input int fl,
                                    output logic [63:0] s, output logic co,
                                    output logic ov, output logic z);
      logic [64:0] mask, aa, bb, full;
      mask = (65'd1 << n) - 65'd1;
      aa   = {1'b0, bt.a} & mask;
      bb   = {1'b0, bt.b} & mask;
      if (!bt.sub) begin
         full = aa + bb + 65'(bt.cin);
         co   = full[n];
         ov   = (aa[n-1] == bb[n-1]) && (full[n-1] != aa[n-1]);
      end else begin
         full = (aa - bb) & mask;
         co   = (aa >= bb);
         ov   = (aa[n-1] != bb[n-1]) && (full[n-1] != aa[n-1]);
      end
      s = full[63:0] & mask[63:0];
      z = (s == 64'd0);
      if (fl == 0) begin
         ov = 1'b0;
         z  = 1'b0;
      end
   endfunction

   // One clock cycle: drive inputs, compare all outputs with the model, advance it.
   task automatic step(input logic iv, input logic [63:0] av, input logic [63:0] bv,
                       input logic ci, input logic sb, input logic ordy, output logic acc);
      logic        exp_v, exp_rdy;
      logic [63:0] es;
      logic        eco, eov, ez;
      beat_t       bt;
      @(negedge clk);
      in_valid  = iv;
      a         = av;
      b         = bv;
      cin       = ci;
      sub       = sb;
      out_ready = ordy;
      #1;
      cyc++;
      exp_v   = (q.size() != 0) && (cyc >= q[0].t + 2);
      exp_rdy = (q.size() < 2) || ordy;
      for (int k = 0; k < NCFG; k++) begin
         check("out_valid", k, 64'(vld_x[k]), 64'(exp_v));
         check("in_ready", k, 64'(rdy_x[k]), 64'(exp_rdy));
         if (exp_v) begin
            ref_calc(q[0], cfg_n(k), cfg_fl(k), es, eco, eov, ez);
            check("sum", k, sum_x[k], es);
            check("cout", k, 64'(cout_x[k]), 64'(eco));
            check("ovf", k, 64'(ovf_x[k]), 64'(eov));
            check("zero", k, 64'(zero_x[k]), 64'(ez));
         end
      end
      if (exp_v && ordy) begin
         for (int k = 0; k < NCFG; k++) begin
            last_sum[k]  = sum_x[k];
            last_cout[k] = cout_x[k];
            last_ovf[k]  = ovf_x[k];
            last_zero[k] = zero_x[k];
         end
         obs.push_back(sum_x[0]);
         obs_cyc.push_back(cyc);
         void'(q.pop_front());
         pops++;
      end
      acc = iv && exp_rdy;
      if (acc) begin
         bt.a   = av;
         bt.b   = bv;
         bt.cin = ci;
         bt.sub = sb;
         bt.t   = cyc;
         q.push_back(bt);
      end
   endtask

   // Single beat through an empty pipe; pins literal results and 2-cycle latency.
   task automatic directed(input string name, input logic [63:0] av, input logic [63:0] bv,
                           input logic ci, input logic sb, input logic [63:0] es,
                           input logic eco, input logic eov, input logic ez);
      logic acc, dummy;
      int   tacc, np;
      acc  = 1'b0;
      tacc = 0;
      np   = pops;
      for (int k = 0; k < 10 && !acc; k++) begin
         step(1'b1, av, bv, ci, sb, 1'b1, acc);
         tacc = cyc;
      end
      check({name, " accepted"}, 0, 64'(acc), 64'd1);
      for (int k = 0; k < 10 && pops == np; k++)
         step(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, dummy);
      check({name, " delivered"}, 0, 64'(pops), 64'(np + 1));
      if (pops == np + 1) begin
         check({name, " latency"}, 0, 64'(obs_cyc[$] - tacc), 64'd2);
         for (int k = 0; k < 2; k++) begin
            check({name, " sum"}, k, last_sum[k], es);
            check({name, " cout"}, k, 64'(last_cout[k]), 64'(eco));
            check({name, " ovf"}, k, 64'(last_ovf[k]), 64'(eov));
            check({name, " zero"}, k, 64'(last_zero[k]), 64'(ez));
         end
      end
   endtask

   function automatic logic [63:0] rnd_op();
      case ($urandom_range(0, 7))
         0: return '1;
         1: return 64'd0;
         2: return 64'h8000_0000_0000_0000;
         3: return 64'h7FFF_FFFF_FFFF_FFFF;
         4: return {8{8'h80}};
         5: return {8{8'h7F}};
         6: return {32'd0, 32'($urandom)};
         default: return {32'($urandom), 32'($urandom)};
      endcase
   endfunction

   // Hard stop if something stalls the main sequence.
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      int   i, accepted, guard;

      // Reset held with a beat offered: everything stays cleared.
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      a         = 64'd5;
      b         = 64'd3;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         for (int k = 0; k < NCFG; k++) begin
            check("reset out_valid", k, 64'(vld_x[k]), 64'd0);
            check("reset sum", k, sum_x[k], 64'd0);
            check("reset cout", k, 64'(cout_x[k]), 64'd0);
            check("reset ovf", k, 64'(ovf_x[k]), 64'd0);
            check("reset zero", k, 64'(zero_x[k]), 64'd0);
         end
      end
      in_valid = 1'b0;
      rst_n    = 1'b1;

      directed("add 5+3", 64'd5, 64'd3, 1'b0, 1'b0, 64'd8, 1'b0, 1'b0, 1'b0);
      directed("carry all groups", '1, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
      directed("sub 10-10", 64'd10, 64'd10, 1'b1, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1);
      directed("sub 0-1", 64'd0, 64'd1, 1'b0, 1'b1, '1, 1'b0, 1'b0, 1'b0);
      directed("sub 5-3 cin0", 64'd5, 64'd3, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0, 1'b0);
      directed("ovf max+1", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
      directed("ovf min-1", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);

      // Back-pressure: offer i+i for i=1..5, consumer stalled for 4 cycles.
      obs.delete();
      obs_cyc.delete();
      i = 1;
      for (int c = 0; c < 4; c++) begin
         step(1'b1, 64'(i), 64'(i), 1'b0, 1'b0, 1'b0, acc);
         if (acc) i++;
      end
      check("bp beats accepted", 0, 64'(i - 1), 64'd2);
      check("bp in_ready low", 0, 64'(rdy_x[0]), 64'd0);
      check("bp out_valid held", 0, 64'(vld_x[0]), 64'd1);
      check("bp held sum", 0, sum_x[0], 64'd2);
      for (int c = 0; c < 20 && obs.size() < 5; c++) begin
         step(i <= 5, 64'(i), 64'(i), 1'b0, 1'b0, 1'b1, acc);
         if (acc) i++;
      end
      check("bp results", 0, 64'(obs.size()), 64'd5);
      if (obs.size() == 5) begin
         for (int j = 0; j < 5; j++) begin
            check("bp order", j, obs[j], 64'(2 * (j + 1)));
            check("bp no gap", j, 64'(obs_cyc[j] - obs_cyc[0]), 64'(j));
         end
      end

      // Reset mid-operation: in-flight beats vanish at once.
      step(1'b1, rnd_op(), rnd_op(), 1'b0, 1'b0, 1'b0, acc);
      step(1'b1, rnd_op(), rnd_op(), 1'b1, 1'b0, 1'b0, acc);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < NCFG; k++) begin
         check("midreset out_valid", k, 64'(vld_x[k]), 64'd0);
         check("midreset sum", k, sum_x[k], 64'd0);
      end
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      directed("post-reset add", 64'd100, 64'd23, 1'b1, 1'b0, 64'd124, 1'b0, 1'b0, 1'b0);

      // Random regression with random valid/ready on both sides.
      accepted = 0;
      guard    = 0;
      while (accepted < 10000 && guard < 60000) begin
         step($urandom_range(0, 3) != 0, rnd_op(), rnd_op(), 1'($urandom),
              1'($urandom), $urandom_range(0, 3) != 0, acc);
         if (acc) accepted++;
         guard++;
      end
      check("random beats accepted", 0, 64'(accepted), 64'd10000);
      for (int c = 0; c < 20 && q.size() != 0; c++)
         step(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, acc);
      check("final drain", 0, 64'(q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cia_pipe_adder.md
Name: cia_pipe_adder

Overview:
- Two-stage pipelined, parametrised carry-increment adder/subtractor with valid/ready flow control on both sides.
- Stage 1 registers bit generate/propagate and per-group local prefix terms.
- Stage 2 resolves group carries, produces sum and flags, and holds them in an output register.
- Intended as the datapath adder in the team's clocked arithmetic units; it replaces the purely combinational variable-group adders wherever a registered, back-pressurable result is needed.

Parameters:
N, 64, operand and sum width in bits (N >= 2).
GS, 8, group size in bits (1 <= GS <= N). Number of groups NG = ceil(N/GS); the last group holds the remaining N - (NG-1)*GS bits.
FLAGS_EN, 1, when 1 the ovf and zero outputs are computed; when 0 they are tied to 0.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  N  operand A, unsigned or two's complement
b  input  N  operand B
cin  input  1  carry in; ignored when sub=1
sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts the result this cycle
sum  output  N  result, modulo 2^N
cout  output  1  carry out of bit N-1 (for sub=1: 1 means no borrow)
ovf  output  1  signed overflow
zero  output  1  sum == 0

Behaviour:
- Clock and reset: one clock domain. rst_n is asynchronous, active-low. It clears s1_valid and s2_valid immediately, so out_valid=0, sum=0, cout=0, ovf=0, zero=0; in_ready=1 once rst_n deasserts. Datapath registers are also cleared to 0.
- Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- Stage 1 capture:
  - bb = sub ? ~b : b; c0 = sub ? 1 : cin.
  - Bit terms: g[i] = a[i]&bb[i], p[i] = a[i]^bb[i].
  - Per group k: the ripple prefix inside the group gives local carries Gl[i], Pl[i] relative to the group LSB, and the group terms GGk, GPk.
  - Registered: p, Gl, Pl, GG, GP, c0, a[N-1], bb[N-1].
- Stage 2 capture:
  - Group carry-in chain: C0 = c0, C(k+1) = GGk | GPk&Ck.
  - Bit carry c[i] = Gl[i-1] | Pl[i-1]&C(group).
  - sum[i] = p[i]^c[i]; cout = C(NG).
  - ovf = (a[N-1] ~^ bb[N-1]) & (sum[N-1] ^ a[N-1]).
  - zero = ~|sum.
- Latency is exactly 2 cycles from input transfer to out_valid, with no stall. Throughput is 1 beat per cycle.
- Elastic pipeline:
  - s2 loads when s1_valid & (~s2_valid | out_ready).
  - s1 loads when in_valid & in_ready.
  - in_ready = ~s1_valid | ~s2_valid | out_ready (combinational from out_ready and state only, never from in_valid).
- Under back-pressure (out_ready=0, both stages full):
  - in_ready=0.
  - sum, cout, ovf and zero hold stable while out_valid=1.
  - No beat is dropped or duplicated.
- Simultaneous output transfer and new input in the same cycle: both stages advance; a full pipeline sustains 1/cycle.
- Ordering is strictly FIFO. At most 2 beats are in flight.
- Wrap-around: sum is modulo 2^N; the carry is reported only on cout.
- Partial last group (N mod GS != 0): it is handled with its reduced width. GS = N degenerates to a single group, equivalent to a ripple adder. GS = 1 degenerates to a ripple adder across groups.
- Reset mid-operation: in-flight beats are discarded. The first out_valid after reset corresponds to a beat accepted after reset.
- sub=1: the cin input has no effect.

Test Plan:
- Reset with in_valid=1 held: out_valid=0 and all outputs 0 during reset. After release, a=5, b=3, sub=0, cin=0 accepted at cycle t gives out_valid at t+2 with sum=8, cout=0, ovf=0, zero=0.
- Carry across every group, N=64, GS=8: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, zero=1, ovf=0. Repeat with GS=7 (partial last group): same result.
- Subtract: a=10, b=10, sub=1, cin=1 -> sum=0, cout=1, zero=1. Then a=0, b=1, sub=1 -> sum=all ones, cout=0, ovf=0.
- Signed overflow, N=64: a=64'h7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=64'h8000_0000_0000_0000, ovf=1, cout=0. Also a=64'h8000_0000_0000_0000, b=1, sub=1 -> ovf=1.
- Back-pressure: stream 5 beats (i+i for i=1..5) with out_ready=0 for 4 cycles. in_ready drops after 2 beats are accepted and the held output stays 2. After out_ready=1, the outputs are 2,4,6,8,10 in order at 1 per cycle, with no gaps once full.
- Random regression: 10k beats with random a/b/cin/sub and random in_valid/out_ready, for N in {8,64} and GS in {1,3,8,N}. Each result is compared with a golden a+b+cin (or a-b) model, including cout, ovf and zero.
